// File: rtl/qdr_app_responder.sv
// QDR user-app command responder: block-RAM backed writes, fixed-latency reads, calibration timer.
// Optional build macro QDR_RESP_INIT_CLEAR_EN: zero-sweep of the RAM while calibrating.
module qdr_app_responder #(
  parameter int QDR_DATA_WIDTH   = 36,
  parameter int QDR_BURST_LENGTH = 4,
  parameter int QDR_ADDR_WIDTH   = 19,
  parameter int MEM_DEPTH_LOG2   = 10,
  parameter int RD_LATENCY       = 8,
  parameter int CALIB_CYCLES     = 64
) (
  input  logic                                       qdr_clk,
  input  logic                                       resetn,
  output logic                                       init_calib_complete,
  input  logic                                       user_app_wr_cmd,
  input  logic [QDR_ADDR_WIDTH-1:0]                  user_app_wr_addr,
  input  logic [QDR_DATA_WIDTH*QDR_BURST_LENGTH-1:0] user_app_wr_data,
  input  logic                                       user_app_rd_cmd,
  input  logic [QDR_ADDR_WIDTH-1:0]                  user_app_rd_addr,
  output logic [QDR_DATA_WIDTH*QDR_BURST_LENGTH-1:0] user_app_rd_data,
  output logic                                       user_app_rd_valid,
  output logic [31:0]                                wr_count,
  output logic [31:0]                                rd_count,
  output logic [15:0]                                drop_count,
  output logic                                       addr_oor
);

  localparam int W     = QDR_DATA_WIDTH * QDR_BURST_LENGTH;
  localparam int DEPTH = 1 << MEM_DEPTH_LOG2;
`ifdef QDR_RESP_INIT_CLEAR_EN
  localparam int CALIB_TARGET = (CALIB_CYCLES > DEPTH) ? CALIB_CYCLES : DEPTH;
`else
  localparam int CALIB_TARGET = CALIB_CYCLES;
`endif
  localparam int CNT_W = $clog2(CALIB_TARGET + 1);

  typedef enum logic [0:0] {ST_CALIB = 1'b0, ST_READY = 1'b1} state_e;

  function automatic logic addr_out_of_range(input logic [QDR_ADDR_WIDTH-1:0] addr);
    addr_out_of_range = (addr >> MEM_DEPTH_LOG2) != {QDR_ADDR_WIDTH{1'b0}};
  endfunction

  state_e                    state_r;
  state_e                    state_nxt_s;
  logic [CNT_W-1:0]          calib_cnt_r;
  logic                      init_r;
  logic                      wr_acc_s;
  logic                      rd_acc_s;
  logic                      wr_oor_s;
  logic                      rd_oor_s;
  logic                      sweep_active_s;
  logic                      mem_we_s;
  logic [MEM_DEPTH_LOG2-1:0] mem_waddr_s;
  logic [W-1:0]              mem_wdata_s;
  logic [W-1:0]              mem_r [0:DEPTH-1];
  logic [W-1:0]              ram_rd_data_r;
  logic [RD_LATENCY:1]       vld_r;
  logic                      oor1_r;
  logic [W-1:0]              data_r [2:RD_LATENCY];
  logic                      rd_valid_r;
  logic [W-1:0]              rd_data_r;
  logic [31:0]               wr_count_r;
  logic [31:0]               rd_count_r;
  logic [15:0]               drop_count_r;
  logic                      addr_oor_r;
  logic [1:0]                drop_inc_s;
  logic [16:0]               drop_sum_s;

  assign wr_acc_s = (state_r == ST_READY) && user_app_wr_cmd;
  assign rd_acc_s = (state_r == ST_READY) && user_app_rd_cmd;
  assign wr_oor_s = addr_out_of_range(user_app_wr_addr);
  assign rd_oor_s = addr_out_of_range(user_app_rd_addr);

`ifdef QDR_RESP_INIT_CLEAR_EN
  // The sweep index is the calibration count itself, so address k is cleared on edge k+1.
  assign sweep_active_s = (state_r == ST_CALIB) && (32'(calib_cnt_r) < 32'(DEPTH));
`else
  assign sweep_active_s = 1'b0;
`endif

  // Next-state decode for the calibration FSM.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_CALIB: begin
        if (calib_cnt_r == CNT_W'(CALIB_TARGET - 1)) begin
          state_nxt_s = ST_READY;
        end else begin
          state_nxt_s = ST_CALIB;
        end
      end
      ST_READY: state_nxt_s = ST_READY;
      default:  state_nxt_s = ST_CALIB;
    endcase
  end

  // State, calibration counter and registered ready flag.
  always_ff @(posedge qdr_clk or negedge resetn) begin
    if (!resetn) begin
      state_r     <= ST_CALIB;
      calib_cnt_r <= {CNT_W{1'b0}};
      init_r      <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      init_r  <= (state_nxt_s == ST_READY);
      if (state_r == ST_CALIB) begin
        calib_cnt_r <= calib_cnt_r + CNT_W'(1);
      end
    end
  end

  // RAM write port source: clearing sweep during calibration, user writes once ready.
  always_comb begin
    mem_we_s    = 1'b0;
    mem_waddr_s = {MEM_DEPTH_LOG2{1'b0}};
    mem_wdata_s = {W{1'b0}};
    if (sweep_active_s) begin
      mem_we_s    = 1'b1;
      mem_waddr_s = calib_cnt_r[MEM_DEPTH_LOG2-1:0];
    end else if (wr_acc_s && !wr_oor_s) begin
      mem_we_s    = 1'b1;
      mem_waddr_s = user_app_wr_addr[MEM_DEPTH_LOG2-1:0];
      mem_wdata_s = user_app_wr_data;
    end else begin
      mem_we_s = 1'b0;
    end
  end

  // Block RAM: the read register samples the old word on a same-address write.
  always_ff @(posedge qdr_clk) begin
    if (mem_we_s) begin
      mem_r[mem_waddr_s] <= mem_wdata_s;
    end
    ram_rd_data_r <= mem_r[user_app_rd_addr[MEM_DEPTH_LOG2-1:0]];
  end

  // Read valid/data shift register behind the RAM stage, plus registered outputs.
  always_ff @(posedge qdr_clk or negedge resetn) begin
    if (!resetn) begin
      vld_r      <= {RD_LATENCY{1'b0}};
      oor1_r     <= 1'b0;
      rd_valid_r <= 1'b0;
      rd_data_r  <= {W{1'b0}};
      for (int k = 2; k <= RD_LATENCY; k++) begin
        data_r[k] <= {W{1'b0}};
      end
    end else begin
      vld_r[1] <= rd_acc_s;
      oor1_r   <= rd_acc_s && rd_oor_s;
      for (int k = 2; k <= RD_LATENCY; k++) begin
        vld_r[k] <= vld_r[k-1];
      end
      data_r[2] <= oor1_r ? {W{1'b0}} : ram_rd_data_r;
      for (int k = 3; k <= RD_LATENCY; k++) begin
        data_r[k] <= data_r[k-1];
      end
      rd_valid_r <= vld_r[RD_LATENCY];
      rd_data_r  <= vld_r[RD_LATENCY] ? data_r[RD_LATENCY] : {W{1'b0}};
    end
  end

  // Dropped-command increment, saturating at the 16-bit ceiling.
  always_comb begin
    drop_inc_s = 2'd0;
    if (state_r == ST_CALIB) begin
      drop_inc_s = {1'b0, user_app_wr_cmd} + {1'b0, user_app_rd_cmd};
    end else begin
      drop_inc_s = 2'd0;
    end
    drop_sum_s = {1'b0, drop_count_r} + {15'd0, drop_inc_s};
  end

  // Statistics counters and the sticky out-of-range flag.
  always_ff @(posedge qdr_clk or negedge resetn) begin
    if (!resetn) begin
      wr_count_r   <= 32'd0;
      rd_count_r   <= 32'd0;
      drop_count_r <= 16'd0;
      addr_oor_r   <= 1'b0;
    end else begin
      if (wr_acc_s) begin
        wr_count_r <= wr_count_r + 32'd1;
      end
      if (rd_acc_s) begin
        rd_count_r <= rd_count_r + 32'd1;
      end
      drop_count_r <= drop_sum_s[16] ? 16'hFFFF : drop_sum_s[15:0];
      addr_oor_r   <= addr_oor_r | (wr_acc_s & wr_oor_s) | (rd_acc_s & rd_oor_s);
    end
  end

  assign init_calib_complete = init_r;
  assign user_app_rd_valid   = rd_valid_r;
  assign user_app_rd_data    = rd_data_r;
  assign wr_count            = wr_count_r;
  assign rd_count            = rd_count_r;
  assign drop_count          = drop_count_r;
  assign addr_oor            = addr_oor_r;

endmodule

// File: tb/tb_qdr_app_responder.sv
// Randomized bench for qdr_app_responder against a cycle-level behavioural model.
// Follows QDR_RESP_INIT_CLEAR_EN to pick the expected calibration length and post-reset contents.
module tb_qdr_app_responder;

  localparam int AW    = 19;
  localparam int W     = 144;
  localparam int LAT   = 8;
  localparam int DEPTH = 1024;
`ifdef QDR_RESP_INIT_CLEAR_EN
  localparam int TARGET = 1024;
`else
  localparam int TARGET = 64;
`endif

  typedef struct {
    int           due;
    logic [W-1:0] data;
    bit           chk;
  } rd_ent_t;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          init_calib_complete;
  logic          wr_cmd = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [W-1:0]  wr_data = '0;
  logic          rd_cmd = 1'b0;
  logic [AW-1:0] rd_addr = '0;
  logic [W-1:0]  rd_data;
  logic          rd_valid;
  logic [31:0]   wr_count;
  logic [31:0]   rd_count;
  logic [15:0]   drop_count;
  logic          addr_oor;

  int            num_checks = 0;
  int            num_errors = 0;
  int            edges = 0;
  logic [31:0]   m_wr = '0;
  logic [31:0]   m_rd = '0;
  int            m_drop = 0;
  logic          m_oor = 1'b0;
  logic [W-1:0]  mem_m [DEPTH];
  bit            known [DEPTH];
  rd_ent_t       pend [$];

  qdr_app_responder dut (
    .qdr_clk             (clk),
    .resetn              (resetn),
    .init_calib_complete (init_calib_complete),
    .user_app_wr_cmd     (wr_cmd),
    .user_app_wr_addr    (wr_addr),
    .user_app_wr_data    (wr_data),
    .user_app_rd_cmd     (rd_cmd),
    .user_app_rd_addr    (rd_addr),
    .user_app_rd_data    (rd_data),
    .user_app_rd_valid   (rd_valid),
    .wr_count            (wr_count),
    .rd_count            (rd_count),
    .drop_count          (drop_count),
    .addr_oor            (addr_oor)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    num_checks++;
    if (got !== exp) begin
      num_errors++;
      $display("FAIL %s at edge %0d: got %0h expected %0h", tag, edges, got, exp);
    end
  endtask

  function automatic logic [W-1:0] rnd_word();
    logic [W-1:0] v;
    v = '0;
    for (int i = 0; i < 5; i++) begin
      v = {v[W-33:0], $urandom()};
    end
    return v;
  endfunction

  // Drive one cycle of commands, advance the model by one edge, then compare every output.
  task automatic tick(input logic wc, input logic [AW-1:0] wa, input logic [W-1:0] wd,
                      input logic rc, input logic [AW-1:0] ra);
    rd_ent_t      e;
    logic         exp_v;
    logic [W-1:0] exp_d;
    bit           exp_chk;
    wr_cmd = wc; wr_addr = wa; wr_data = wd;
    rd_cmd = rc; rd_addr = ra;
    if (edges >= TARGET) begin
      if (rc) begin
        m_rd  = m_rd + 32'd1;
        e.due = edges + 1 + LAT;
        if (int'(ra) >= DEPTH) begin
          e.data = '0; e.chk = 1'b1; m_oor = 1'b1;
        end else begin
          e.data = mem_m[int'(ra)]; e.chk = known[int'(ra)];
        end
        pend.push_back(e);
      end
      if (wc) begin
        m_wr = m_wr + 32'd1;
        if (int'(wa) >= DEPTH) begin
          m_oor = 1'b1;
        end else begin
          mem_m[int'(wa)] = wd; known[int'(wa)] = 1'b1;
        end
      end
    end else begin
      m_drop = m_drop + int'(wc) + int'(rc);
      if (m_drop > 65535) m_drop = 65535;
    end
    edges++;
    @(posedge clk); #1;
    exp_v = 1'b0; exp_d = '0; exp_chk = 1'b1;
    if (pend.size() > 0 && pend[0].due == edges) begin
      e = pend.pop_front();
      exp_v = 1'b1; exp_d = e.data; exp_chk = e.chk;
    end
    check("init_calib_complete", W'(init_calib_complete), W'(edges >= TARGET));
    check("rd_valid", W'(rd_valid), W'(exp_v));
    if (exp_chk) check("rd_data", rd_data, exp_d);
    check("wr_count", W'(wr_count), W'(m_wr));
    check("rd_count", W'(rd_count), W'(m_rd));
    check("drop_count", W'(drop_count), W'(m_drop));
    check("addr_oor", W'(addr_oor), W'(m_oor));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, '0, '0, 1'b0, '0);
  endtask

  task automatic apply_reset(input int n);
    resetn = 1'b0;
    wr_cmd = 1'b0; rd_cmd = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      check("rst_rd_valid", W'(rd_valid), '0);
      check("rst_init", W'(init_calib_complete), '0);
      check("rst_rd_count", W'(rd_count), '0);
      check("rst_drop_count", W'(drop_count), '0);
    end
    pend.delete();
    edges = 0; m_wr = '0; m_rd = '0; m_drop = 0; m_oor = 1'b0;
`ifdef QDR_RESP_INIT_CLEAR_EN
    for (int i = 0; i < DEPTH; i++) begin
      mem_m[i] = '0; known[i] = 1'b1;
    end
`endif
    resetn = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_m[i] = '0; known[i] = 1'b0;
    end
    apply_reset(3);

    // Commands during calibration are dropped.
    for (int c = 0; c < TARGET + 4; c++) begin
      tick(c == 20, '0, '0, c == 10, '0);
    end

    // Single write then read.
    tick(1'b1, 19'h005, {4{36'h0000000A5}}, 1'b0, '0);
    tick(1'b0, '0, '0, 1'b1, 19'h005);
    idle(12);

    // Sixteen writes then sixteen back-to-back reads.
    for (int i = 0; i < 16; i++) tick(1'b1, AW'(i), W'(i), 1'b0, '0);
    for (int i = 0; i < 16; i++) tick(1'b0, '0, '0, 1'b1, AW'(i));
    idle(12);

    // Read-before-write on a same-cycle collision.
    tick(1'b1, 19'h003, W'(1), 1'b0, '0);
    tick(1'b1, 19'h003, W'(2), 1'b1, 19'h003);
    tick(1'b0, '0, '0, 1'b1, 19'h003);
    idle(12);

    // Random in-range traffic.
    for (int i = 0; i < 400; i++) begin
      tick(1'($urandom_range(0, 1)), AW'($urandom_range(0, 63)), rnd_word(),
           1'($urandom_range(0, 1)), AW'($urandom_range(0, 63)));
    end
    idle(12);

    // Out-of-range read and write.
    tick(1'b1, 19'h003FF, rnd_word(), 1'b0, '0);
    tick(1'b0, '0, '0, 1'b1, 19'h00400);
    idle(12);
    tick(1'b1, 19'h7FFFF, rnd_word(), 1'b0, '0);
    tick(1'b0, '0, '0, 1'b1, 19'h003FF);
    idle(12);

    // Reset with reads in flight, then recalibrate under random dropped traffic.
    tick(1'b0, '0, '0, 1'b1, 19'h001);
    tick(1'b0, '0, '0, 1'b1, 19'h002);
    tick(1'b0, '0, '0, 1'b1, 19'h005);
    apply_reset(2);
    for (int c = 0; c < TARGET + 4; c++) begin
      tick(1'($urandom_range(0, 1)), 19'h010, rnd_word(), 1'($urandom_range(0, 1)), 19'h010);
    end
    idle(12);
    tick(1'b0, '0, '0, 1'b1, 19'h005);
    idle(12);

    $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
    $finish;
  end

endmodule
